phy_crc_engine: RTL and testbench
=================================

// Module: phy_crc_engine
// PURPOSE
// - Parametrised serial-beat CRC engine for the PHY datapath. Successor to the fixed 4-bit CRC32 checker.
// - Per frame, selectable mode:
//   - CHECK: residue compare plus a saturating fail counter.
//   - GEN: computes the CRC and then emits it as DATA_W-bit beats on a valid/ready TX port, to append to outgoing frames.
// PARAMETERS
// DATA_W    4             bits per beat; CRC_W % DATA_W must be 0
// CRC_W     32            CRC register width
// POLY      32'h04C11DB7  generator polynomial, implicit x^CRC_W term
// INIT      32'hFFFFFFFF  register seed at frame start
// RESIDUE   32'hC704DD7B  register value after data+CRC of a good frame (CHECK mode)
// CNT_W     8             width of the fail counter
// PORTS
// clk            in   1       clock
// rst            in   1       asynchronous, active-high reset
// crc_start      in   1       synchronous frame restart/abort
// crc_mode       in   1       0=GEN, 1=CHECK; sampled on first beat of a frame
// crc_data_in    in   DATA_W  data beat, bit 0 transmitted first
// crc_data_en    in   1       beat valid
// crc_data_last  in   1       beat is last of frame (carries data)
// crc_data_ready out  1       engine can accept a beat
// crc_out        out  CRC_W   final CRC, reflected and inverted
// crc_out_valid  out  1       1-cycle pulse: crc_out/crc_out_fail updated
// crc_out_fail   out  1       CHECK frame residue mismatch; 0 for GEN frames
// crc_tx_data    out  DATA_W  GEN-mode CRC beat
// crc_tx_valid   out  1       CRC beat valid
// crc_tx_ready   in   1       downstream accepts CRC beat
// crc_fail_cnt   out  CNT_W   failed CHECK frames, saturating
// BEHAVIOUR
// - Reset: state IDLE; crc_reg=INIT; crc_data_ready=1; crc_out=0; crc_out_valid=0; crc_out_fail=0; crc_tx_valid=0; crc_tx_data=0; crc_fail_cnt=0.
// - Beat accept: crc_data_en & crc_data_ready.
// - Per accepted beat, bits j=0..DATA_W-1 are processed in order, all in one cycle:
//   - fb = d[j] ^ reg[CRC_W-1]
//   - reg = {reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
// - States:
//   - IDLE: ready=1. An accepted beat latches crc_mode and goes to DATA, or is handled as a last beat if crc_data_last=1.
//   - DATA: ready=1; accepts beats.
//   - TX: ready=0; emits CRC beats.
// - Accepted last beat, with reg' = crc_reg updated by that beat:
//   - next cycle: crc_out = ~bitrev(reg'); crc_out_valid=1 for exactly one cycle
//   - crc_reg reloads INIT in that same edge
//   - CHECK: crc_out_fail = (reg' != RESIDUE); crc_fail_cnt increments on fail, holding at all-ones. Next state IDLE, so back-to-back frames run with no bubble.
//   - GEN: crc_out_fail=0; next state TX with beat index k=0.
// - TX:
//   - crc_tx_valid=1; crc_tx_data = crc_out[k*DATA_W +: DATA_W].
//   - k advances on crc_tx_valid & crc_tx_ready.
//   - After beat CRC_W/DATA_W-1 handshakes, go to IDLE with crc_tx_valid=0 the next cycle.
//   - crc_tx_data holds steady while valid & !ready.
// - crc_start, when state!=TX or a TX handshake is pending, has highest priority:
//   - crc_reg=INIT, state=IDLE, crc_tx_valid=0; crc_out and crc_fail_cnt unchanged; no crc_out_valid.
//   - A beat accepted in the same cycle is processed as the first beat of a new frame, seeded with INIT and with mode latched.
// - crc_data_en while ready=0 is ignored; the source must hold the beat.
// - crc_data_last without crc_data_en is ignored.
// - An asynchronous rst mid-frame or mid-TX returns everything to reset values immediately.
// TESTING
// - Data in all tests: "123456789" (0x31..0x39), low nibble first.
// - GEN, DATA_W=4, data above -> one cycle after last beat: crc_out=32'hCBF43926, crc_out_valid=1, crc_out_fail=0. TX beats 6,2,9,3,4,F,B,C.
// - CHECK, data above then 26 39 F4 CB -> crc_out_fail=0, crc_fail_cnt stays 0. Repeat with last nibble 0xD -> fail=1, cnt=1.
// - TX backpressure: hold crc_tx_ready=0 for 5 cycles on beat 3 -> crc_tx_data stays 3, crc_data_ready=0 throughout, no beat lost.
// - Back-to-back CHECK frames with no idle cycle -> two crc_out_valid pulses exactly (frame length) beats apart, both correct.
// - crc_start mid-frame or mid-TX -> the next frame's CRC matches a fresh computation; tx_valid drops the next cycle.
// - 260 bad CHECK frames -> crc_fail_cnt saturates at 8'hFF.
// - rst asserted mid-TX -> all outputs at reset values.
// - Repeat the golden vector with DATA_W=1, 8 and 16.

Source files
------------

// File: rtl/phy_crc_engine_if.sv
// phy_crc_engine_if: beat input, result, and CRC TX port bundle for phy_crc_engine
interface phy_crc_engine_if #(
  parameter int DATA_W = 4,
  parameter int CRC_W = 32,
  parameter int CNT_W = 8
);
  logic crc_start, crc_mode, crc_data_en, crc_data_last, crc_data_ready;
  logic crc_out_valid, crc_out_fail, crc_tx_valid, crc_tx_ready;
  logic [DATA_W-1:0] crc_data_in, crc_tx_data;
  logic [CRC_W-1:0] crc_out;
  logic [CNT_W-1:0] crc_fail_cnt;
  modport master (
    output crc_start, crc_mode, crc_data_in, crc_data_en, crc_data_last, crc_tx_ready,
    input crc_data_ready, crc_out, crc_out_valid, crc_out_fail, crc_tx_data, crc_tx_valid, crc_fail_cnt
  );
  modport slave (
    input crc_start, crc_mode, crc_data_in, crc_data_en, crc_data_last, crc_tx_ready,
    output crc_data_ready, crc_out, crc_out_valid, crc_out_fail, crc_tx_data, crc_tx_valid, crc_fail_cnt
  );
endinterface

// File: rtl/phy_crc_engine.sv
// phy_crc_engine: serial-beat CRC with residue check mode and CRC-beat generation mode
module phy_crc_engine #(
  parameter int DATA_W = 4,
  parameter int CRC_W = 32,
  parameter logic [CRC_W-1:0] POLY = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] RESIDUE = 32'hC704DD7B,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  phy_crc_engine_if.slave bus
);
  localparam int NB = CRC_W / DATA_W;
  localparam int KW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, DATA, TX} state_t;
  state_t state, state_nx;
  logic [CRC_W-1:0] crc_reg, crc_nx, crc_rev;
  logic [KW-1:0] k;
  logic mode_q, mode_eff, accept, last_acc, bad, tx_hs, tx_done;
  assign accept = bus.crc_data_en & bus.crc_data_ready;
  assign last_acc = accept & bus.crc_data_last;
  assign mode_eff = (state == IDLE || bus.crc_start) ? bus.crc_mode : mode_q;
  assign bad = mode_eff & (crc_nx != RESIDUE);
  assign tx_hs = bus.crc_tx_valid & bus.crc_tx_ready;
  assign tx_done = tx_hs & (k == KW'(NB - 1));
  assign bus.crc_data_ready = state != TX;
  assign bus.crc_tx_valid = state == TX;
  assign bus.crc_tx_data = (state == TX) ? bus.crc_out[k*DATA_W +: DATA_W] : '0;
  // fold one beat into the register, LSB first; a restart seeds the beat with INIT
  always_comb begin
    crc_nx = bus.crc_start ? INIT : crc_reg;
    for (int j = 0; j < DATA_W; j++)
      crc_nx = {crc_nx[CRC_W-2:0], 1'b0} ^ ((bus.crc_data_in[j] ^ crc_nx[CRC_W-1]) ? POLY : '0);
    for (int j = 0; j < CRC_W; j++)
      crc_rev[j] = crc_nx[CRC_W-1-j];
  end
  // next state: frame end beats restart and abort, then TX completion
  always_comb begin
    state_nx = last_acc ? (mode_eff ? IDLE : TX) : accept ? DATA : (bus.crc_start | tx_done) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // CRC register, frame result, fail counter, and TX beat index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg <= INIT;
      mode_q <= 1'b0;
      k <= '0;
      bus.crc_out <= '0;
      bus.crc_out_valid <= 1'b0;
      bus.crc_out_fail <= 1'b0;
      bus.crc_fail_cnt <= '0;
    end else begin
      bus.crc_out_valid <= last_acc;
      crc_reg <= last_acc ? INIT : accept ? crc_nx : bus.crc_start ? INIT : crc_reg;
      if (accept) mode_q <= mode_eff;
      k <= (state != TX) ? '0 : tx_hs ? k + 1'b1 : k;
      if (last_acc) begin
        bus.crc_out <= ~crc_rev;
        bus.crc_out_fail <= bad;
        if (bad && bus.crc_fail_cnt != {CNT_W{1'b1}}) bus.crc_fail_cnt <= bus.crc_fail_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phy_crc_engine.sv
// tb_phy_crc_engine: vector table, corner sequences and random frames against a byte-wise CRC-32 model
module tb_phy_crc_engine;
  logic clk = 0;
  logic rst = 1;
  int errors = 0, checks = 0, cyc = 0, npulse = 0;
  logic [7:0] mcnt = 0;
  localparam logic [71:0] MSG = 72'h393837363534333231;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit mode;
    int n;
    logic [103:0] d;
    logic [31:0] crc;
    bit chk_crc;
    bit fail;
    logic [7:0] cnt;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phy_crc_engine_if b();
  phy_crc_engine dut (.clk(clk), .rst(rst), .bus(b.slave));

  always @(negedge clk) if (b.crc_out_valid) npulse <= npulse + 1;

  function automatic logic [31:0] crc32(input bq_t m, input int n);
    logic [31:0] c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, m[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction

  function automatic bit frame_bad(input bq_t m);
    int n = m.size();
    return crc32(m, n - 4) != {m[n-1], m[n-2], m[n-3], m[n-4]};
  endfunction

  function automatic bq_t mk(input int nd, input bit corrupt);
    bq_t q;
    logic [31:0] c;
    for (int i = 0; i < nd; i++) q.push_back(8'($urandom));
    c = crc32(q, nd);
    for (int i = 0; i < 4; i++) q.push_back(c[i*8 +: 8]);
    if (corrupt) q[nd+3] = q[nd+3] ^ 8'h01;
    return q;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_ready"}, b.crc_data_ready, 1);
    chk({t, "_out"}, b.crc_out, 0);
    chk({t, "_valid"}, b.crc_out_valid, 0);
    chk({t, "_fail"}, b.crc_out_fail, 0);
    chk({t, "_tx_valid"}, b.crc_tx_valid, 0);
    chk({t, "_tx_data"}, b.crc_tx_data, 0);
    chk({t, "_cnt"}, b.crc_fail_cnt, 0);
  endtask

  task automatic send(input bit mode, input bq_t m, input int gap, input bit st, input bit nolast);
    for (int i = 0; i < m.size() * 2; i++) begin
      while ($urandom_range(99) < gap) begin
        b.crc_data_en = 0;
        b.crc_data_last = 1'($urandom);
        b.crc_data_in = 4'($urandom);
        b.crc_mode = 1'($urandom);
        @(posedge clk); #1;
      end
      b.crc_data_en = 1;
      b.crc_data_in = i[0] ? m[i/2][7:4] : m[i/2][3:0];
      b.crc_data_last = !nolast && i == m.size() * 2 - 1;
      b.crc_mode = i == 0 ? mode : ~mode;
      b.crc_start = st && i == 0;
      @(posedge clk); #1;
    end
    b.crc_data_en = 0;
    b.crc_data_last = 0;
    b.crc_start = 0;
  endtask

  task automatic expect_out(input bit mode, input bq_t m);
    bit bad = mode && frame_bad(m);
    if (bad && mcnt != 8'hFF) mcnt++;
    chk("out_valid", b.crc_out_valid, 1);
    chk("crc_out", b.crc_out, crc32(m, m.size()));
    chk("out_fail", b.crc_out_fail, 32'(bad));
    chk("fail_cnt", b.crc_fail_cnt, mcnt);
  endtask

  task automatic tx_collect(input logic [31:0] e, input int sk, input int sn, input int nb, input bit rnd);
    for (int kk = 0; kk < nb; kk++) begin
      int stall = (kk == sk) ? sn : rnd ? int'($urandom_range(2)) : 0;
      chk("tx_valid", b.crc_tx_valid, 1);
      repeat (stall) begin
        chk("tx_hold", b.crc_tx_data, e[kk*4 +: 4]);
        chk("ready_in_tx", b.crc_data_ready, 0);
        @(posedge clk); #1;
      end
      chk("tx_data", b.crc_tx_data, e[kk*4 +: 4]);
      b.crc_tx_ready = 1;
      @(posedge clk); #1;
      b.crc_tx_ready = 0;
    end
    if (nb == 8) begin
      chk("tx_end_valid", b.crc_tx_valid, 0);
      chk("tx_end_ready", b.crc_data_ready, 1);
    end
  endtask

  for (genvar w = 0; w < 3; w++) begin : g
    localparam int DW = w == 0 ? 1 : w == 1 ? 8 : 16;
    localparam int NBY = DW == 16 ? 8 : 9;
    int errs = 0, chks = 0;
    bit done = 0;
    phy_crc_engine_if #(.DATA_W(DW)) gi();
    phy_crc_engine #(.DATA_W(DW)) gd (.clk(clk), .rst(rst), .bus(gi.slave));
    task automatic gchk(input string n, input logic [31:0] a, input logic [31:0] x);
      chks++;
      if (a !== x) begin
        errs++;
        $display("FAIL %s dw=%0d: got %h expected %h", n, DW, a, x);
      end
    endtask
    initial begin
      logic [71:0] s;
      bq_t q;
      logic [31:0] e;
      s = MSG;
      for (int i = 0; i < NBY; i++) q.push_back(s[i*8 +: 8]);
      e = crc32(q, NBY);
      gi.crc_start = 0;
      gi.crc_mode = 0;
      gi.crc_data_en = 0;
      gi.crc_data_last = 0;
      gi.crc_data_in = '0;
      gi.crc_tx_ready = 1;
      @(negedge rst);
      @(posedge clk); #1;
      for (int i = 0; i < NBY * 8 / DW; i++) begin
        gi.crc_data_en = 1;
        gi.crc_data_in = s[i*DW +: DW];
        gi.crc_data_last = i == NBY * 8 / DW - 1;
        @(posedge clk); #1;
      end
      gi.crc_data_en = 0;
      gi.crc_data_last = 0;
      gchk("g_valid", gi.crc_out_valid, 1);
      gchk("g_crc", gi.crc_out, e);
      gchk("g_fail", gi.crc_out_fail, 0);
      for (int kk = 0; kk < 32 / DW; kk++) begin
        gchk("g_tx_valid", gi.crc_tx_valid, 1);
        gchk("g_tx_data", gi.crc_tx_data, e[kk*DW +: DW]);
        @(posedge clk); #1;
      end
      gchk("g_tx_end", gi.crc_tx_valid, 0);
      done = 1;
    end
  end

  initial begin
    vec_t tv[3];
    bq_t gold, qa, qb, q;
    int p0, c0;
    bit mode;
    tv[0] = '{0, 9, {32'h0, MSG}, 32'hCBF43926, 1, 0, 8'd0};
    tv[1] = '{1, 13, {32'hCBF43926, MSG}, 32'h2144DF1C, 1, 0, 8'd0};
    tv[2] = '{1, 13, {32'hDBF43926, MSG}, 32'h0, 0, 1, 8'd1};
    for (int i = 0; i < 9; i++) gold.push_back(tv[0].d[i*8 +: 8]);
    for (int i = 0; i < 13; i++) qa.push_back(tv[1].d[i*8 +: 8]);
    b.crc_start = 0;
    b.crc_mode = 0;
    b.crc_data_in = '0;
    b.crc_data_en = 0;
    b.crc_data_last = 0;
    b.crc_tx_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk_reset("reset");
    foreach (tv[t]) begin
      q = {};
      for (int i = 0; i < tv[t].n; i++) q.push_back(tv[t].d[i*8 +: 8]);
      send(tv[t].mode, q, 0, 0, 0);
      expect_out(tv[t].mode, q);
      if (tv[t].chk_crc) chk("tv_crc", b.crc_out, tv[t].crc);
      chk("tv_fail", b.crc_out_fail, 32'(tv[t].fail));
      chk("tv_cnt", b.crc_fail_cnt, tv[t].cnt);
      if (!tv[t].mode) tx_collect(tv[t].crc, -1, 0, 8, 0);
    end
    send(0, gold, 0, 0, 0);
    expect_out(0, gold);
    tx_collect(32'hCBF43926, 3, 5, 8, 0);
    qb = mk(6, 0);
    p0 = npulse;
    send(1, qa, 0, 0, 0);
    c0 = cyc;
    expect_out(1, qa);
    send(1, qb, 0, 0, 0);
    chk("b2b_gap", cyc - c0, qb.size() * 2);
    expect_out(1, qb);
    @(posedge clk); #1;
    chk("b2b_pulses", npulse - p0, 2);
    p0 = npulse;
    send(1, mk(4, 1), 0, 0, 1);
    send(0, gold, 0, 1, 0);
    expect_out(0, gold);
    tx_collect(32'hCBF43926, -1, 0, 8, 1);
    chk("start_pulses", npulse - p0, 1);
    send(0, mk(3, 0), 0, 0, 1);
    b.crc_start = 1;
    @(posedge clk); #1;
    b.crc_start = 0;
    send(1, qa, 0, 0, 0);
    expect_out(1, qa);
    send(0, gold, 0, 0, 0);
    expect_out(0, gold);
    tx_collect(32'hCBF43926, -1, 0, 2, 0);
    p0 = npulse;
    b.crc_start = 1;
    @(posedge clk); #1;
    b.crc_start = 0;
    chk("abort_tx_valid", b.crc_tx_valid, 0);
    chk("abort_ready", b.crc_data_ready, 1);
    chk("abort_crc_out", b.crc_out, 32'hCBF43926);
    @(posedge clk); #1;
    chk("abort_no_pulse", npulse - p0, 0);
    q = mk(3, 0);
    send(0, q, 20, 0, 0);
    expect_out(0, q);
    tx_collect(crc32(q, q.size()), -1, 0, 8, 1);
    repeat (40) begin
      mode = 1'($urandom);
      if (mode) q = mk($urandom_range(1, 8), 1'($urandom));
      else begin
        q = {};
        repeat ($urandom_range(1, 10)) q.push_back(8'($urandom));
      end
      send(mode, q, 25, 0, 0);
      expect_out(mode, q);
      if (!mode) tx_collect(crc32(q, q.size()), -1, 0, 8, 1);
    end
    repeat (260) begin
      q = mk(1, 1);
      send(1, q, 0, 0, 0);
      expect_out(1, q);
    end
    chk("cnt_sat", b.crc_fail_cnt, 8'hFF);
    for (int t = 0; t < 5000 && !(g[0].done && g[1].done && g[2].done); t++) @(posedge clk);
    #1;
    chk("width_runs_done", {g[0].done, g[1].done, g[2].done}, 3'b111);
    send(0, gold, 0, 0, 0);
    expect_out(0, gold);
    tx_collect(32'hCBF43926, -1, 0, 3, 0);
    #2 rst = 1;
    #1 chk_reset("rst_mid_tx");
    mcnt = 0;
    #1 rst = 0;
    @(posedge clk); #1;
    send(0, gold, 0, 0, 0);
    expect_out(0, gold);
    tx_collect(32'hCBF43926, -1, 0, 8, 0);
    errors += g[0].errs + g[1].errs + g[2].errs;
    checks += g[0].chks + g[1].chks + g[2].chks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
